// File: rtl/mem_operand_reader_pkg.sv
// Shared definitions for the memory operand reader.
//   AW_DEF / DW_DEF : default address and data widths
//   word_t          : one data word at the default width
//   state_t         : fetch sequencer states
package mem_operand_reader_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef logic [DW_DEF-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        CAP_A = 3'd2,
        RD_B  = 3'd3,
        CAP_B = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_operand_reader_if.sv
// Request, memory-port, snoop and result signals of the operand reader.
//   slave  : the reader itself (takes the request, drives the read port and results)
//   master : the requester / memory / execute side
interface mem_operand_reader_if
    import mem_operand_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    // request
    logic          start;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic          needA;
    logic          needB;
    // synchronous read port
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] rdData;
    // stage-3 write snoop
    logic          fwdWE;
    logic [AW-1:0] fwdAddr;
    logic [DW-1:0] fwdData;
    // result handshake
    logic          exReady;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic          opValid;
    logic          busy;

    modport slave (
        input  start, addrA, addrB, needA, needB,
        input  rdData, fwdWE, fwdAddr, fwdData, exReady,
        output rdEn, rdAddr, opA, opB, opValid, busy
    );

    modport master (
        output start, addrA, addrB, needA, needB,
        output rdData, fwdWE, fwdAddr, fwdData, exReady,
        input  rdEn, rdAddr, opA, opB, opValid, busy
    );

endinterface

// File: rtl/mem_operand_reader_fwd_select.sv
// Write-snoop forwarding for one read in flight, shared by both operands.
//   issue/issue_addr : a read is being issued this cycle at issue_addr
//   capture/cap_addr : the read for cap_addr returns and is captured this cycle
//   fwd_*            : stage-3 write bus
//   rd_data          : memory read data
//   sel_data         : value to capture (current write > held write > memory)
module fwd_select
    import mem_operand_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          issue,
    input  logic [AW-1:0] issue_addr,
    input  logic          capture,
    input  logic [AW-1:0] cap_addr,
    input  logic          fwd_we,
    input  logic [AW-1:0] fwd_addr,
    input  logic [DW-1:0] fwd_data,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] sel_data
);

    logic          hold_vld;
    logic [DW-1:0] hold_data;
    logic          issue_hit;
    logic          cap_hit;

    // A write landing on the issue edge is missed by the memory read
    // (read-before-write), so its data is parked until the capture.
    assign issue_hit = issue && fwd_we && (fwd_addr == issue_addr);
    assign cap_hit   = fwd_we && (fwd_addr == cap_addr);

    // CAP_A can capture A and issue B in the same cycle: the clear for A
    // must not wipe a hit recorded for B, so the set is written last.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hold_vld  <= 1'b0;
            hold_data <= '0;
        end else begin
            if (capture) hold_vld <= 1'b0;
            if (issue_hit) begin
                hold_vld  <= 1'b1;
                hold_data <= fwd_data;
            end
        end
    end

    // The youngest write wins: one racing the capture beats the held one.
    always_comb begin
        sel_data = rd_data;
        if (cap_hit)       sel_data = fwd_data;
        else if (hold_vld) sel_data = hold_data;
    end

endmodule

// File: rtl/mem_operand_reader.sv
// Operand fetch: reads up to two memory operands (A then B) over one
// synchronous read port and hands them to execute with opValid/exReady.
//   CLK   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request, read port, stage-3 snoop and result handshake
module mem_operand_reader
    import mem_operand_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic               CLK,
    input  logic               reset,
    mem_operand_reader_if.slave bus
);

    state_t        state, state_nx;

    logic [AW-1:0] addr_a, addr_b;
    logic          need_a, need_b;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] rdaddr_q;

    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          cap;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] sel_data;
    logic          accept;

    assign accept = (state == IDLE) && bus.start;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // ---------------- next state / read port decode ----------------
    // rdEn comes purely from the registered state; rdAddr falls back to
    // the last issued address when no read is issued.
    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        rd_addr  = rdaddr_q;
        cap      = 1'b0;
        cap_addr = addr_a;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.needA)      state_nx = RD_A;
                    else if (bus.needB) state_nx = RD_B;
                    else                state_nx = DONE;
                end
            end
            RD_A: begin
                rd_en    = 1'b1;
                rd_addr  = addr_a;
                state_nx = CAP_A;
            end
            CAP_A: begin
                cap      = 1'b1;
                cap_addr = addr_a;
                // overlap the B read with the A capture
                if (need_b) begin
                    rd_en    = 1'b1;
                    rd_addr  = addr_b;
                    state_nx = CAP_B;
                end else begin
                    state_nx = DONE;
                end
            end
            RD_B: begin
                rd_en    = 1'b1;
                rd_addr  = addr_b;
                state_nx = CAP_B;
            end
            CAP_B: begin
                cap      = 1'b1;
                cap_addr = addr_b;
                state_nx = DONE;
            end
            DONE: begin
                if (bus.exReady) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- request latch and operand registers ----------------
    // Operands are cleared on accept so an unneeded one reads as zero.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            addr_a   <= '0;
            addr_b   <= '0;
            need_a   <= 1'b0;
            need_b   <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            rdaddr_q <= '0;
        end else begin
            if (rd_en) rdaddr_q <= rd_addr;
            if (accept) begin
                addr_a <= bus.addrA;
                addr_b <= bus.addrB;
                need_a <= bus.needA;
                need_b <= bus.needB;
                op_a   <= '0;
                op_b   <= '0;
            end
            if (state == CAP_A) op_a <= sel_data;
            if (state == CAP_B) op_b <= sel_data;
        end
    end

    fwd_select #(
        .AW (AW),
        .DW (DW)
    ) u_fwd (
        .CLK        (CLK),
        .reset      (reset),
        .issue      (rd_en),
        .issue_addr (rd_addr),
        .capture    (cap),
        .cap_addr   (cap_addr),
        .fwd_we     (bus.fwdWE),
        .fwd_addr   (bus.fwdAddr),
        .fwd_data   (bus.fwdData),
        .rd_data    (bus.rdData),
        .sel_data   (sel_data)
    );

    // ---------------- outputs ----------------
    assign bus.rdEn    = rd_en;
    assign bus.rdAddr  = rd_addr;
    assign bus.opA     = op_a;
    assign bus.opB     = op_b;
    assign bus.opValid = (state == DONE);
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_operand_reader.sv
// Bench for mem_operand_reader: a per-cycle expectation timeline is built
// from the fetch rules (latency, issue/capture cycles, forwarding priority)
// and one negedge process compares every cycle against it.
module tb_mem_operand_reader;
    import mem_operand_reader_pkg::*;

    localparam int NC = 4096;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    mem_operand_reader_if #(.AW(16), .DW(16)) bus();

    mem_operand_reader #(.AW(16), .DW(16)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // expectation timeline (default = idle)
    bit        e_rst   [NC];
    bit        e_busy  [NC];
    bit        e_valid [NC];
    bit        e_rden  [NC];
    bit [15:0] e_rdaddr[NC];
    bit [15:0] e_opa   [NC];
    bit [15:0] e_opb   [NC];
    // stage-3 write schedule
    bit        f_we    [NC];
    bit [15:0] f_addr  [NC];
    bit [15:0] f_data  [NC];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // preloaded read-only memory contents
    function automatic word_t memval(input word_t a);
        if (a == 16'd4) return 16'd17;
        if (a == 16'd6) return 16'd12;
        return word_t'(a * 16'd37 + 16'd5);
    endfunction

    // operand issued in cycle ic, captured at the end of ic+1
    function automatic word_t model_op(input word_t a, input int ic);
        if (f_we[ic+1] && f_addr[ic+1] == a) return f_data[ic+1];
        if (f_we[ic] && f_addr[ic] == a)     return f_data[ic];
        return memval(a);
    endfunction

    always @(posedge CLK) bus.rdData <= bus.rdEn ? memval(bus.rdAddr) : word_t'($urandom);

    // observation of the most recent opValid rise
    int    rise_cyc = -1;
    word_t obs_a, obs_b;
    bit    prev_valid = 1'b0;
    int    rden_cnt = 0;

    always @(negedge CLK) begin
        if (cyc < NC) begin
            if (e_rst[cyc]) begin
                chk("rst_busy",  bus.busy,    0);
                chk("rst_valid", bus.opValid, 0);
                chk("rst_rden",  bus.rdEn,    0);
                chk("rst_rdaddr",bus.rdAddr,  0);
                chk("rst_opa",   bus.opA,     0);
                chk("rst_opb",   bus.opB,     0);
            end else begin
                chk("busy",  bus.busy,    e_busy[cyc]);
                chk("valid", bus.opValid, e_valid[cyc]);
                chk("rden",  bus.rdEn,    e_rden[cyc]);
                if (e_rden[cyc])  chk("rdaddr", bus.rdAddr, e_rdaddr[cyc]);
                if (e_valid[cyc]) begin
                    chk("opa", bus.opA, e_opa[cyc]);
                    chk("opb", bus.opB, e_opb[cyc]);
                end
            end
            if (bus.opValid && !prev_valid) begin
                rise_cyc = cyc;
                obs_a    = bus.opA;
                obs_b    = bus.opB;
            end
            prev_valid = bus.opValid;
            if (bus.rdEn) rden_cnt++;
        end
    end

    // One fetch, started in the current cycle (called at posedge+1, DUT idle).
    task automatic fetch(input bit na, input bit nb, input word_t aa, input word_t ab,
                         input int stall, input bit rnd, input bit spam,
                         output word_t xa, output word_t xb);
        int n, len, ib;
        n   = cyc;
        len = (na && nb) ? 4 : (na || nb) ? 3 : 1;
        if (rnd) for (int k = 0; k <= len + stall; k++) begin
            f_we[n+k]   = 1'($urandom_range(0, 1));
            f_addr[n+k] = word_t'($urandom_range(0, 15));
            f_data[n+k] = word_t'($urandom);
        end
        ib = na ? n + 2 : n + 1;
        xa = na ? model_op(aa, n + 1) : 16'd0;
        xb = nb ? model_op(ab, ib) : 16'd0;
        for (int k = 1; k <= len + stall; k++) e_busy[n+k] = 1'b1;
        if (na) begin e_rden[n+1] = 1'b1; e_rdaddr[n+1] = aa; end
        if (nb) begin e_rden[ib]  = 1'b1; e_rdaddr[ib]  = ab; end
        for (int k = len; k <= len + stall; k++) begin
            e_valid[n+k] = 1'b1;
            e_opa[n+k]   = xa;
            e_opb[n+k]   = xb;
        end
        for (int k = 0; k <= len + stall; k++) begin
            bus.start   = (k == 0) || ($urandom_range(0, 3) == 0) || (spam && k >= len);
            bus.addrA   = (k == 0) ? aa : word_t'($urandom);
            bus.addrB   = (k == 0) ? ab : word_t'($urandom);
            bus.needA   = (k == 0) ? na : 1'($urandom_range(0, 1));
            bus.needB   = (k == 0) ? nb : 1'($urandom_range(0, 1));
            bus.fwdWE   = f_we[n+k];
            bus.fwdAddr = f_addr[n+k];
            bus.fwdData = f_data[n+k];
            bus.exReady = (k == len + stall) ? 1'b1 :
                          (k >= len) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
        end
        bus.start   = 1'b0;
        bus.fwdWE   = 1'b0;
        bus.exReady = 1'b0;
    endtask

    // Both-operand fetch of 4/6 with reset pulled during CAP_A.
    task automatic abort_fetch();
        int n;
        n = cyc;
        e_busy[n+1] = 1'b1; e_rden[n+1] = 1'b1; e_rdaddr[n+1] = 16'd4;
        for (int k = 2; k <= 5; k++) e_rst[n+k] = 1'b1;
        bus.start = 1'b1; bus.addrA = 16'd4; bus.addrB = 16'd6;
        bus.needA = 1'b1; bus.needB = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b0;
        #1;
        chk("abort_valid", bus.opValid, 0);
        chk("abort_busy",  bus.busy,    0);
        chk("abort_rden",  bus.rdEn,    0);
        chk("abort_rdaddr",bus.rdAddr,  0);
        chk("abort_opa",   bus.opA,     0);
        chk("abort_opb",   bus.opB,     0);
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        word_t xa, xb;
        int    n0, r0;
        reset = 1'b0;
        bus.start = 1'b0; bus.addrA = '0; bus.addrB = '0;
        bus.needA = 1'b0; bus.needB = 1'b0;
        bus.fwdWE = 1'b0; bus.fwdAddr = '0; bus.fwdData = '0; bus.exReady = 1'b0;
        for (int k = 0; k <= 3; k++) e_rst[k] = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b1;

        // both operands: 17 / 12, valid at N+4, two reads
        n0 = cyc; r0 = rden_cnt;
        fetch(1, 1, 16'd4, 16'd6, 0, 0, 0, xa, xb);
        chk("pin_ab_a", xa, 17); chk("pin_ab_b", xb, 12);
        chk("dut_ab_a", obs_a, 17); chk("dut_ab_b", obs_b, 12);
        chk("lat_ab", rise_cyc - n0, 4); chk("rden_ab", rden_cnt - r0, 2);

        // A only
        n0 = cyc;
        fetch(1, 0, 16'd6, 16'd9, 0, 0, 0, xa, xb);
        chk("pin_a_a", xa, 12); chk("dut_a_a", obs_a, 12); chk("dut_a_b", obs_b, 0);
        chk("lat_a", rise_cyc - n0, 3);

        // neither
        n0 = cyc; r0 = rden_cnt;
        fetch(0, 0, 16'd4, 16'd6, 0, 0, 0, xa, xb);
        chk("dut_none_a", obs_a, 0); chk("dut_none_b", obs_b, 0);
        chk("lat_none", rise_cyc - n0, 1); chk("rden_none", rden_cnt - r0, 0);

        // write racing the A capture
        n0 = cyc;
        f_we[n0+2] = 1'b1; f_addr[n0+2] = 16'd4; f_data[n0+2] = 16'd1;
        fetch(1, 0, 16'd4, 16'd0, 0, 0, 0, xa, xb);
        chk("pin_capfwd", xa, 1); chk("dut_capfwd", obs_a, 1);
        n0 = cyc;
        f_we[n0+2] = 1'b1; f_addr[n0+2] = 16'd5; f_data[n0+2] = 16'd1;
        fetch(1, 0, 16'd4, 16'd0, 0, 0, 0, xa, xb);
        chk("pin_capmiss", xa, 17); chk("dut_capmiss", obs_a, 17);

        // write on the B issue edge only -> hold register
        n0 = cyc;
        f_we[n0+2] = 1'b1; f_addr[n0+2] = 16'd6; f_data[n0+2] = 16'd99;
        fetch(1, 1, 16'd4, 16'd6, 0, 0, 0, xa, xb);
        chk("pin_hold_b", xb, 99); chk("dut_hold_a", obs_a, 17); chk("dut_hold_b", obs_b, 99);
        // plus a capture-edge write: capture edge wins
        n0 = cyc;
        f_we[n0+2] = 1'b1; f_addr[n0+2] = 16'd6; f_data[n0+2] = 16'd99;
        f_we[n0+3] = 1'b1; f_addr[n0+3] = 16'd6; f_data[n0+3] = 16'd55;
        fetch(1, 1, 16'd4, 16'd6, 0, 0, 0, xa, xb);
        chk("pin_both_b", xb, 55); chk("dut_both_b", obs_b, 55);

        // execute stall of 3 cycles with start pulses in DONE
        fetch(1, 1, 16'd6, 16'd4, 3, 0, 1, xa, xb);
        chk("dut_stall_a", obs_a, 12); chk("dut_stall_b", obs_b, 17);
        chk("busy_after", bus.busy, 0);

        // reset mid-fetch, then a clean fetch
        abort_fetch();
        fetch(1, 1, 16'd4, 16'd6, 0, 0, 0, xa, xb);
        chk("dut_post_a", obs_a, 17); chk("dut_post_b", obs_b, 12);

        // randomized fetches with random snoop traffic
        for (int i = 0; i < 150; i++) begin
            fetch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  word_t'($urandom_range(0, 15)), word_t'($urandom_range(0, 15)),
                  $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)), xa, xb);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end

        repeat (2) @(posedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_operand_reader.md
# mem_operand_reader

Operand-fetch block for the memory-to-memory datapath: reads up to two 16-bit source operands (A, B) from data memory over a single synchronous read port and presents them to the execute stage with a valid/ready handshake. It is the read-side counterpart of the stage-3 memory writer. It snoops the stage-3 write bus so that an operand read racing a same-address write returns the newly written value.

## Interface
Parameters:
- AW, 16, memory address width
- DW, 16, data word width

Ports:
- CLK  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a fetch; sampled only in IDLE
- addrA  in  AW  operand A address
- addrB  in  AW  operand B address
- needA  in  1  operand A is a memory operand
- needB  in  1  operand B is a memory operand
- rdEn  out  1  memory read enable
- rdAddr  out  AW  memory read address
- rdData  in  DW  memory read data, valid the cycle after rdEn
- fwdWE  in  1  stage-3 write enable (writeMem & WEaluOut)
- fwdAddr  in  AW  stage-3 write address
- fwdData  in  DW  stage-3 write data
- exReady  in  1  execute stage accepts operands
- opA  out  DW  operand A
- opB  out  DW  operand B
- opValid  out  1  opA/opB valid
- busy  out  1  fetch in progress (state != IDLE)

## Operation
- States: IDLE, RD_A, CAP_A, RD_B, CAP_B, DONE.
- IDLE, start=1: latch addrA, addrB, needA, needB; clear opA, opB. Next state is RD_A if needA, else RD_B if needB, else DONE.
- RD_A: rdEn=1, rdAddr=addrA. Next state CAP_A.
- CAP_A: capture opA. If needB, also drive rdEn=1, rdAddr=addrB and go to CAP_B; otherwise go to DONE.
- RD_B: rdEn=1, rdAddr=addrB. Next state CAP_B.
- CAP_B: capture opB. Next state DONE.
- DONE: opValid=1 and opA/opB held stable. exReady=1 returns the block to IDLE. start is ignored outside IDLE.
- An operand whose need flag is 0 reads as 0.
- Forwarding:
  - On each issue edge (end of RD_A, RD_B, or CAP_A issuing B), if fwdWE and fwdAddr == issue address, latch fwdData into a hold register and set hold flag.
  - At capture, priority is: (1) current fwdWE with fwdAddr == operand address → fwdData; (2) hold flag set → hold register; (3) rdData.
  - The hold flag is cleared at every capture.
- Address compare is a full AW-bit equality check, with no wrap or masking.

## Timing
- Reset (async assert, sync release): state IDLE; opA=0, opB=0, opValid=0, busy=0, rdEn=0, rdAddr=0; hold flag cleared.
- Latency from the start-sampling edge N to opValid high:
  - both operands needed: cycle N+4
  - exactly one operand needed: cycle N+3
  - neither needed: cycle N+1
- rdEn is a registered-state decode with no combinational path from start.
- opValid stays high until exReady is sampled at 1; exReady during that same DONE cycle counts as the transfer.
- Back-to-back fetches: start is accepted no earlier than the cycle after DONE exits.
- Reset asserted mid-fetch aborts immediately. No opValid pulse is produced and any captured operand is discarded.
- A write that coincides with the issue edge and another write that coincides with the capture edge: the capture-edge write wins.
- rdAddr outside RD_A, RD_B, and the CAP_A issue holds its last value; only rdEn qualifies it.

## Structure
- The shared package holds the state enum, AW/DW defaults, and the word type.
- One sub-module, `fwd_select`: address compare, hold register/flag, and the three-way capture mux. It is instantiated once and shared by both operands.
- The top level holds the FSM, latched request fields, and the opA/opB registers.

## Test plan
Bench memory is preloaded with mem[4]=17 and mem[6]=12. Reset is pulsed low at start.
- needA=needB=1, addrA=4, addrB=6, exReady=1 → opValid rises 4 cycles after start, with opA=17, opB=12. rdEn pulses at addresses 4 then 6.
- needA=1, needB=0, addrA=6 → opA=12, opB=0, opValid at N+3. needA=needB=0 → opValid at N+1 with no rdEn.
- Fetch A=4 while fwdWE=1, fwdAddr=4, fwdData=1 in the CAP_A cycle → opA=1. Repeat with fwdAddr=5 → opA=17.
- fwdWE at addr 6, data 99, on the B issue edge only → opB=99 from the hold register. If a second write of 55 to addr 6 also occurs in CAP_B → opB=55.
- exReady=0 for 3 cycles in DONE → opValid, opA, and opB remain stable and a start pulse is ignored. exReady=1 → IDLE next cycle, busy=0.
- reset driven low during CAP_A → all outputs 0 immediately, with no opValid. A fresh fetch after release returns correct values.
